k12a_sequencer: RTL and testbench
=================================

// Module: k12a_sequencer
// PURPOSE
//   Multi-cycle control sequencer for the k12a core. Holds the current state_t
//   and decides the next one each cycle from memory, decoder and interrupt inputs.
//   Emits the per-state control strobes to the datapath, PC and memory interface.
//   Sits between the instruction decoder and the datapath. Owns wait-state
//   handling, bus timeout, halt and interrupt entry.
// PARAMETERS
//   MEM_TIMEOUT  15  Max consecutive wait cycles (mem_req & ~mem_ready) before bus error; legal 1..255
// PORTS
//   cpu_clock      in   1        core clock; all state updates on rising edge
//   reset_n        in   1        asynchronous, active-low reset
//   mem_ready      in   1        memory completes current access this cycle
//   instr_class    in   instr_class_t  decoder output; valid in STATE_DECODE only
//   irq            in   1        level interrupt request
//   irq_enable     in   1        interrupt enable flag from status register
//   run            in   1        resume pulse; used only in STATE_HALT
//   state          out  state_t  current sequencer state
//   mem_req        out  1        memory access request
//   mem_we         out  1        write enable; valid only with mem_req
//   addr_sel_pc    out  1        1: address = PC, 0: address = data address register
//   ir_load_hi     out  1        load IR high byte from memory data
//   ir_load_lo     out  1        load IR low byte from memory data
//   pc_inc         out  1        increment PC
//   pc_load_vec    out  1        load PC with interrupt vector
//   reg_we         out  1        register file write
//   irq_ack        out  1        interrupt acknowledge, one cycle
//   halted         out  1        registered; 1 while in STATE_HALT
//   bus_error      out  1        registered, sticky; set on timeout
// BEHAVIOUR
//   Reset (async assert, sync to cpu_clock release):
//     state=STATE_FETCH1, class_q=CLASS_ALU, wait_cnt=0, halted=0, bus_error=0.
//     No strobe asserts while reset_n=0.
//   Strobes: combinational from state, class_q, mem_ready. state, class_q, wait_cnt,
//     halted, bus_error: registered.
//   FETCH1: mem_req=1, addr_sel_pc=1. If mem_ready: ir_load_hi=1, pc_inc=1 -> FETCH2.
//   FETCH2: as FETCH1 but ir_load_lo=1 -> DECODE.
//   DECODE: one cycle, no strobes. class_q<=instr_class.
//     ALU->EXECUTE; LOAD/STORE->MEMORY; HALT->HALT.
//   EXECUTE: reg_we=1 for one cycle -> INTERRUPT if irq&irq_enable, else FETCH1.
//   MEMORY: mem_req=1, addr_sel_pc=0, mem_we=(class_q==CLASS_STORE).
//     On mem_ready: reg_we=(class_q==CLASS_LOAD). Exit as EXECUTE.
//   HALT: halted=1. irq&irq_enable -> INTERRUPT; else run -> FETCH1 and clear bus_error;
//     else stay. irq wins over run in the same cycle.
//   INTERRUPT: irq_ack=1, pc_load_vec=1 for exactly one cycle -> FETCH1.
//   Interrupt sampling: only at instruction boundaries (EXECUTE/MEMORY exit) and in HALT.
//     Never mid-fetch.
//   Wait timer: wait_cnt increments each cycle with mem_req & ~mem_ready.
//     Clears on any state change or on mem_ready. Saturates, never wraps.
//   Timeout: wait_cnt==MEM_TIMEOUT-1 & ~mem_ready -> bus_error<=1, next state HALT, no load strobes.
//     If mem_ready is high on that cycle, the transfer completes normally (ready wins).
//   Zero-wait memory (mem_ready=1 always): ALU instr = 4 cycles; LOAD/STORE = 4 cycles.
//     Both paths take FETCH1, FETCH2, DECODE, then EXECUTE or MEMORY.
//   Reset mid-access: state returns to FETCH1 immediately. A pending access is abandoned;
//     memory tolerates mem_req dropping.
//   Illegal/unused state_t encodings: next state FETCH1, no strobes.
// STRUCTURE
//   In the shared k12a include/package:
//     - state_t gains STATE_FETCH2, STATE_DECODE, STATE_EXECUTE, STATE_MEMORY,
//       STATE_HALT, STATE_INTERRUPT.
//     - instr_class_t {CLASS_ALU, CLASS_LOAD, CLASS_STORE, CLASS_HALT}.
//     - K12A_IRQ_VECTOR constant.
//   Sub-module k12a_wait_timer (parameter MEM_TIMEOUT): wait_cnt counter plus timeout
//     flag; inputs count_en, clear.
//   Next-state and strobe decode: one always_comb block; flops in one
//     always_ff on cpu_clock / negedge reset_n.
// TESTING
//   1. Reset mid-FETCH2 with mem_ready=0 -> state=FETCH1 asynchronously; all strobes 0;
//      halted=0; bus_error=0.
//   2. mem_ready=1, ALU instr -> FETCH1,FETCH2,DECODE,EXECUTE,FETCH1 (4 cycles).
//      ir_load_hi, ir_load_lo, reg_we one cycle each; pc_inc twice.
//   3. STORE with mem_ready low 3 cycles in MEMORY -> mem_req=mem_we=1 for 4 cycles;
//      reg_we never asserts; then FETCH1.
//   4. MEM_TIMEOUT=15, mem_ready=0 forever in FETCH1 -> bus_error=1 and HALT after 15
//      cycles. run pulse -> FETCH1, bus_error=0. Repeat with mem_ready=1 on 15th cycle:
//      no error.
//   5. irq=1, irq_enable=1 raised during FETCH1 of ALU instr -> instruction completes;
//      INTERRUPT follows EXECUTE; irq_ack and pc_load_vec for 1 cycle. irq_enable=0 -> no entry.
//   6. HALT instr, then irq=1, irq_enable=1 and run=1 in same cycle -> INTERRUPT (not FETCH1);
//      halted=1 in HALT, 0 after.

Source files
------------

// File: rtl/k12a_pkg.sv
// Shared k12a types: sequencer states, decoder instruction classes, control
// strobe bundle and the interrupt vector address.
package k12a_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLASS_W = 2;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] K12A_IRQ_VECTOR = 16'h0004;

  typedef enum logic [STATE_W-1:0] {
    STATE_FETCH1    = 3'd0,
    STATE_FETCH2    = 3'd1,
    STATE_DECODE    = 3'd2,
    STATE_EXECUTE   = 3'd3,
    STATE_MEMORY    = 3'd4,
    STATE_HALT      = 3'd5,
    STATE_INTERRUPT = 3'd6
  } state_t;

  typedef enum logic [CLASS_W-1:0] {
    CLASS_ALU   = 2'd0,
    CLASS_LOAD  = 2'd1,
    CLASS_STORE = 2'd2,
    CLASS_HALT  = 2'd3
  } instr_class_t;

  // Per-cycle control strobes driven toward datapath, PC and memory.
  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic addr_sel_pc;
    logic ir_load_hi;
    logic ir_load_lo;
    logic pc_inc;
    logic pc_load_vec;
    logic reg_we;
    logic irq_ack;
  } strobes_t;

endpackage

// File: rtl/k12a_wait_timer.sv
// Memory wait-state counter with bus-timeout flag.
//   cpu_clock, reset_n : clock, async active-low reset
//   count_en           : a memory request is waiting this cycle
//   clear              : restart counting (access done or state changing)
//   timeout_c          : counter sits at its last legal value (MEM_TIMEOUT-1)
module k12a_wait_timer
  import k12a_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic cpu_clock,
  input  logic reset_n,
  input  logic count_en,
  input  logic clear,
  output logic timeout_c
);

  localparam logic [WAIT_W-1:0] CNT_MAX   = '1;
  localparam logic [WAIT_W-1:0] CNT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Saturating wait counter; clear has priority over counting.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count_en && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign timeout_c = (wait_cnt == CNT_LIMIT);

endmodule

// File: rtl/k12a_sequencer.sv
// Multi-cycle control sequencer for the k12a core: fetch (two bytes), decode,
// execute or memory access, halt and interrupt entry, with bus timeout.
//   cpu_clock, reset_n            : clock, async active-low reset
//   mem_ready                     : memory finishes the current access
//   instr_class                   : decoder class, sampled in STATE_DECODE
//   irq, irq_enable, run          : interrupt request/enable, resume from halt
//   state                         : current state (registered)
//   mem_req .. irq_ack            : control strobes (combinational, 0 in reset)
//   halted, bus_error             : registered status, bus_error is sticky
module k12a_sequencer
  import k12a_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic         cpu_clock,
  input  logic         reset_n,
  input  logic         mem_ready,
  input  instr_class_t instr_class,
  input  logic         irq,
  input  logic         irq_enable,
  input  logic         run,
  output state_t       state,
  output logic         mem_req,
  output logic         mem_we,
  output logic         addr_sel_pc,
  output logic         ir_load_hi,
  output logic         ir_load_lo,
  output logic         pc_inc,
  output logic         pc_load_vec,
  output logic         reg_we,
  output logic         irq_ack,
  output logic         halted,
  output logic         bus_error
);

  state_t       state_nxt;
  instr_class_t class_q;
  instr_class_t class_nxt;
  logic         bus_error_nxt;
  strobes_t     strb_c;
  strobes_t     strb_out;
  logic         timeout_c;
  logic         irq_take_c;
  logic         expired_c;

  assign irq_take_c = irq & irq_enable;
  assign expired_c  = timeout_c & ~mem_ready;

  // Next-state and strobe decode.
  always_comb begin
    state_nxt     = state;
    class_nxt     = class_q;
    bus_error_nxt = bus_error;
    strb_c        = '0;

    case (state)
      STATE_FETCH1: begin
        strb_c.mem_req     = 1'b1;
        strb_c.addr_sel_pc = 1'b1;
        if (mem_ready) begin
          strb_c.ir_load_hi = 1'b1;
          strb_c.pc_inc     = 1'b1;
          state_nxt         = STATE_FETCH2;
        end else if (expired_c) begin
          bus_error_nxt = 1'b1;
          state_nxt     = STATE_HALT;
        end
      end

      STATE_FETCH2: begin
        strb_c.mem_req     = 1'b1;
        strb_c.addr_sel_pc = 1'b1;
        if (mem_ready) begin
          strb_c.ir_load_lo = 1'b1;
          strb_c.pc_inc     = 1'b1;
          state_nxt         = STATE_DECODE;
        end else if (expired_c) begin
          bus_error_nxt = 1'b1;
          state_nxt     = STATE_HALT;
        end
      end

      STATE_DECODE: begin
        class_nxt = instr_class;
        case (instr_class)
          CLASS_ALU:               state_nxt = STATE_EXECUTE;
          CLASS_LOAD, CLASS_STORE: state_nxt = STATE_MEMORY;
          default:                 state_nxt = STATE_HALT;
        endcase
      end

      // Instruction boundary: the only place besides HALT where irq is taken.
      STATE_EXECUTE: begin
        strb_c.reg_we = 1'b1;
        state_nxt     = irq_take_c ? STATE_INTERRUPT : STATE_FETCH1;
      end

      STATE_MEMORY: begin
        strb_c.mem_req = 1'b1;
        strb_c.mem_we  = (class_q == CLASS_STORE);
        if (mem_ready) begin
          strb_c.reg_we = (class_q == CLASS_LOAD);
          state_nxt     = irq_take_c ? STATE_INTERRUPT : STATE_FETCH1;
        end else if (expired_c) begin
          bus_error_nxt = 1'b1;
          state_nxt     = STATE_HALT;
        end
      end

      // irq beats run; only a run resume clears a latched bus error.
      STATE_HALT: begin
        if (irq_take_c) begin
          state_nxt = STATE_INTERRUPT;
        end else if (run) begin
          state_nxt     = STATE_FETCH1;
          bus_error_nxt = 1'b0;
        end
      end

      STATE_INTERRUPT: begin
        strb_c.irq_ack     = 1'b1;
        strb_c.pc_load_vec = 1'b1;
        state_nxt          = STATE_FETCH1;
      end

      default: begin
        state_nxt = STATE_FETCH1;
      end
    endcase
  end

  // State and status flops.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= STATE_FETCH1;
      class_q   <= CLASS_ALU;
      halted    <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      class_q   <= class_nxt;
      halted    <= (state_nxt == STATE_HALT);
      bus_error <= bus_error_nxt;
    end
  end

  // Wait counter restarts on completion or whenever the state moves on.
  k12a_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .cpu_clock(cpu_clock),
    .reset_n  (reset_n),
    .count_en (strb_c.mem_req & ~mem_ready),
    .clear    (mem_ready | (state_nxt != state)),
    .timeout_c(timeout_c)
  );

  // Reset forces FETCH1, whose fetch strobes must stay quiet until release.
  assign strb_out    = reset_n ? strb_c : '0;
  assign mem_req     = strb_out.mem_req;
  assign mem_we      = strb_out.mem_we;
  assign addr_sel_pc = strb_out.addr_sel_pc;
  assign ir_load_hi  = strb_out.ir_load_hi;
  assign ir_load_lo  = strb_out.ir_load_lo;
  assign pc_inc      = strb_out.pc_inc;
  assign pc_load_vec = strb_out.pc_load_vec;
  assign reg_we      = strb_out.reg_we;
  assign irq_ack     = strb_out.irq_ack;

endmodule

// File: tb/tb_k12a_sequencer.sv
// Bench for k12a_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a rule-based reference model.
module tb_k12a_sequencer;
  import k12a_pkg::*;

  localparam int unsigned MEM_TIMEOUT = 15;

  logic         cpu_clock = 1'b0;
  logic         reset_n;
  logic         mem_ready;
  instr_class_t instr_class;
  logic         irq;
  logic         irq_enable;
  logic         run;
  state_t       state;
  logic         mem_req, mem_we, addr_sel_pc, ir_load_hi, ir_load_lo;
  logic         pc_inc, pc_load_vec, reg_we, irq_ack, halted, bus_error;

  k12a_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .cpu_clock  (cpu_clock),
    .reset_n    (reset_n),
    .mem_ready  (mem_ready),
    .instr_class(instr_class),
    .irq        (irq),
    .irq_enable (irq_enable),
    .run        (run),
    .state      (state),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel_pc(addr_sel_pc),
    .ir_load_hi (ir_load_hi),
    .ir_load_lo (ir_load_lo),
    .pc_inc     (pc_inc),
    .pc_load_vec(pc_load_vec),
    .reg_we     (reg_we),
    .irq_ack    (irq_ack),
    .halted     (halted),
    .bus_error  (bus_error)
  );

  always #5 cpu_clock = ~cpu_clock;

  int checks = 0;
  int passed = 0;

  // Reference model state.
  state_t       m_state;
  instr_class_t m_class;
  int           m_waits;
  bit           m_err;

  // Per-cycle samples and strobe tallies for the directed checks.
  state_t seen_st[$];
  bit     seen_halt[$];
  bit     seen_berr[$];
  int n_pc_inc, n_ir_hi, n_ir_lo, n_reg_we, n_mem_we, n_mem_req, n_irq_ack, n_vec;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = STATE_FETCH1;
    m_class = CLASS_ALU;
    m_waits = 0;
    m_err   = 1'b0;
  endtask

  task automatic clr();
    seen_st.delete();
    seen_halt.delete();
    seen_berr.delete();
    n_pc_inc = 0; n_ir_hi = 0; n_ir_lo = 0; n_reg_we = 0;
    n_mem_we = 0; n_mem_req = 0; n_irq_ack = 0; n_vec = 0;
  endtask

  function automatic logic [8:0] dut_strobes();
    return {mem_req, mem_we, addr_sel_pc, ir_load_hi, ir_load_lo,
            pc_inc, pc_load_vec, reg_we, irq_ack};
  endfunction

  // One clock: drive inputs, compare all outputs with the model, then advance it.
  task automatic cyc(input bit rst, input bit mr, input instr_class_t ic,
                     input bit rq, input bit ie, input bit rn);
    bit fetch, mem_phase, fault, boundary, take;
    logic [8:0] exp_s, act_s;
    state_t nxt;
    @(negedge cpu_clock);
    reset_n = !rst; mem_ready = mr; instr_class = ic;
    irq = rq; irq_enable = ie; run = rn;
    if (rst) model_reset();
    #1;
    fetch     = (m_state == STATE_FETCH1) || (m_state == STATE_FETCH2);
    mem_phase = fetch || (m_state == STATE_MEMORY);
    fault     = !rst && mem_phase && !mr && (m_waits + 1 >= int'(MEM_TIMEOUT));
    boundary  = (m_state == STATE_EXECUTE) || (m_state == STATE_MEMORY && mr);
    take      = rq && ie;
    exp_s = '0;
    if (!rst)
      exp_s = {mem_phase,
               (m_state == STATE_MEMORY) && (m_class == CLASS_STORE),
               fetch,
               (m_state == STATE_FETCH1) && mr,
               (m_state == STATE_FETCH2) && mr,
               fetch && mr,
               m_state == STATE_INTERRUPT,
               (m_state == STATE_EXECUTE) ||
                 ((m_state == STATE_MEMORY) && mr && (m_class == CLASS_LOAD)),
               m_state == STATE_INTERRUPT};
    act_s = dut_strobes();
    check("state", int'(state), int'(m_state));
    check("strobes", int'(act_s), int'(exp_s));
    check("halted", int'(halted), int'(m_state == STATE_HALT));
    check("bus_error", int'(bus_error), int'(m_err));
    seen_st.push_back(state);
    seen_halt.push_back(halted);
    seen_berr.push_back(bus_error);
    n_mem_req += int'(mem_req);  n_mem_we += int'(mem_we);
    n_ir_hi   += int'(ir_load_hi); n_ir_lo += int'(ir_load_lo);
    n_pc_inc  += int'(pc_inc);   n_reg_we += int'(reg_we);
    n_irq_ack += int'(irq_ack);  n_vec    += int'(pc_load_vec);

    if (fault)         nxt = STATE_HALT;
    else if (boundary) nxt = take ? STATE_INTERRUPT : STATE_FETCH1;
    else case (m_state)
      STATE_FETCH1: nxt = mr ? STATE_FETCH2 : STATE_FETCH1;
      STATE_FETCH2: nxt = mr ? STATE_DECODE : STATE_FETCH2;
      STATE_DECODE: nxt = (ic == CLASS_ALU)  ? STATE_EXECUTE :
                          (ic == CLASS_HALT) ? STATE_HALT : STATE_MEMORY;
      STATE_MEMORY: nxt = STATE_MEMORY;
      STATE_HALT:   nxt = take ? STATE_INTERRUPT : (rn ? STATE_FETCH1 : STATE_HALT);
      default:      nxt = STATE_FETCH1;
    endcase

    @(posedge cpu_clock);
    if (!rst) begin
      if (fault) m_err = 1'b1;
      else if (m_state == STATE_HALT && !take && rn) m_err = 1'b0;
      if (m_state == STATE_DECODE) m_class = ic;
      if (nxt != m_state || mr || !mem_phase) m_waits = 0;
      else if (m_waits < 255) m_waits = m_waits + 1;
      m_state = nxt;
    end
  endtask

  initial begin
    int stall;
    bit mr;
    reset_n = 1'b0; mem_ready = 1'b0; instr_class = CLASS_ALU;
    irq = 1'b0; irq_enable = 1'b0; run = 1'b0;
    model_reset();
    clr();
    repeat (2) cyc(1, 1, CLASS_ALU, 0, 0, 0);

    // Zero-wait ALU instruction.
    clr();
    repeat (4) cyc(0, 1, CLASS_ALU, 0, 0, 0);
    check("alu_seq0", int'(seen_st[0]), int'(STATE_FETCH1));
    check("alu_seq1", int'(seen_st[1]), int'(STATE_FETCH2));
    check("alu_seq2", int'(seen_st[2]), int'(STATE_DECODE));
    check("alu_seq3", int'(seen_st[3]), int'(STATE_EXECUTE));
    check("alu_pc_inc", n_pc_inc, 2);
    check("alu_ir_hi", n_ir_hi, 1);
    check("alu_ir_lo", n_ir_lo, 1);
    check("alu_reg_we", n_reg_we, 1);

    // STORE with three wait cycles in MEMORY.
    clr();
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_STORE, 0, 0, 0);
    check("alu_exit", int'(seen_st[0]), int'(STATE_FETCH1));
    clr();
    repeat (3) cyc(0, 0, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    check("st_in_mem", int'(seen_st[0]), int'(STATE_MEMORY));
    check("st_mem_req", n_mem_req, 4);
    check("st_mem_we", n_mem_we, 4);
    check("st_reg_we", n_reg_we, 0);

    // Fetch timeout, irq out of HALT keeps bus_error, then reset mid-FETCH2.
    clr();
    repeat (15) cyc(0, 0, CLASS_ALU, 0, 0, 0);
    cyc(0, 0, CLASS_ALU, 1, 1, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 0, CLASS_ALU, 0, 0, 0);
    check("st_exit", int'(seen_st[0]), int'(STATE_FETCH1));
    check("to_14_state", int'(seen_st[14]), int'(STATE_FETCH1));
    check("to_14_berr", int'(seen_berr[14]), 0);
    check("to_halt", int'(seen_st[15]), int'(STATE_HALT));
    check("to_berr", int'(seen_berr[15]), 1);
    check("to_halted", int'(seen_halt[15]), 1);
    check("to_irq_entry", int'(seen_st[16]), int'(STATE_INTERRUPT));
    check("to_berr_sticky", int'(seen_berr[16]), 1);
    check("pre_rst_f2", int'(seen_st[18]), int'(STATE_FETCH2));

    @(negedge cpu_clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_state", int'(state), int'(STATE_FETCH1));
    check("rst_strobes", int'(dut_strobes()), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_berr", int'(bus_error), 0);
    model_reset();
    cyc(1, 0, CLASS_ALU, 0, 0, 0);

    // Timeout then run resume; then ready arriving on the 15th wait cycle.
    clr();
    repeat (15) cyc(0, 0, CLASS_ALU, 0, 0, 0);
    cyc(0, 0, CLASS_ALU, 0, 0, 1);
    repeat (14) cyc(0, 0, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    check("run_halt", int'(seen_st[15]), int'(STATE_HALT));
    check("run_berr_set", int'(seen_berr[15]), 1);
    check("run_resume", int'(seen_st[16]), int'(STATE_FETCH1));
    check("run_berr_clr", int'(seen_berr[16]), 0);
    check("late_ready_f1", int'(seen_st[30]), int'(STATE_FETCH1));
    check("late_ready_f2", int'(seen_st[31]), int'(STATE_FETCH2));
    check("late_ready_berr", int'(seen_berr[31]), 0);

    // Interrupt raised during FETCH1 is taken only after EXECUTE.
    clr();
    repeat (5) cyc(0, 1, CLASS_ALU, 1, 1, 0);
    repeat (4) cyc(0, 1, CLASS_ALU, 1, 0, 0);
    cyc(0, 0, CLASS_ALU, 1, 0, 0);
    check("irq_exec", int'(seen_st[3]), int'(STATE_EXECUTE));
    check("irq_entry", int'(seen_st[4]), int'(STATE_INTERRUPT));
    check("irq_return", int'(seen_st[5]), int'(STATE_FETCH1));
    check("irq_masked_exec", int'(seen_st[8]), int'(STATE_EXECUTE));
    check("irq_masked_next", int'(seen_st[9]), int'(STATE_FETCH1));
    check("irq_ack_count", n_irq_ack, 1);
    check("irq_vec_count", n_vec, 1);

    // HALT instruction; irq beats run in the same cycle.
    clr();
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_HALT, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 1, CLASS_ALU, 1, 1, 1);
    cyc(0, 1, CLASS_ALU, 0, 0, 0);
    cyc(0, 0, CLASS_ALU, 0, 0, 0);
    check("hlt_state", int'(seen_st[3]), int'(STATE_HALT));
    check("hlt_halted", int'(seen_halt[3]), 1);
    check("hlt_halted2", int'(seen_halt[4]), 1);
    check("hlt_irq_wins", int'(seen_st[5]), int'(STATE_INTERRUPT));
    check("hlt_halted_clr", int'(seen_halt[5]), 0);
    check("hlt_after_int", int'(seen_st[6]), int'(STATE_FETCH1));

    // Random traffic with occasional long stalls and resets.
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (stall > 0) begin
        mr = 1'b0;
        stall--;
      end else begin
        mr = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 150) == 0) stall = $urandom_range(10, 20);
      end
      cyc($urandom_range(0, 299) == 0, mr,
          instr_class_t'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
